// File: rtl/serial_lane_arbiter.sv
// serial_lane_arbiter: shares one serial-to-parallel deserializer among
// n_lanes serial bit sources. One lane is granted for exactly one width-bit
// word, so every parallel word comes from a single lane. Each finished word
// is tagged with its source lane on word_owner.
//
// Handshake: a lane bit is consumed on a cycle where lane_valid[i] and
// lane_ready[i] are both high. lane_ready is a function of state and grant
// only; it never looks at lane_valid.
//
// Build option: define SERIAL_LANE_ARB_PRIORITY_EN for fixed priority
// (lowest valid lane always wins). Default is round-robin.
module serial_lane_arbiter #(
  parameter int width   = 8,
  parameter int n_lanes = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [n_lanes-1:0]         lane_valid,
  input  logic [n_lanes-1:0]         lane_data,
  output logic [n_lanes-1:0]         lane_ready,
  output logic                       serial_valid,
  output logic                       serial_data,
  output logic [$clog2(n_lanes)-1:0] owner,
  output logic                       word_done,
  output logic [$clog2(n_lanes)-1:0] word_owner,
  output logic                       dbg_busy
);

  localparam int lw = $clog2(n_lanes);
  localparam int cw = $clog2(width);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [lw-1:0]   grant_q, grant_d;
  logic [cw-1:0]   bit_cnt_q, bit_cnt_d;
  logic [lw-1:0]   ptr_q, ptr_d;
  logic            serial_valid_q, serial_valid_d;
  logic            serial_data_q, serial_data_d;
  logic            word_done_q, word_done_d;
  logic [lw-1:0]   word_owner_q, word_owner_d;

  logic [n_lanes-1:0] rot_valid;
  logic [lw-1:0]      first_pos;
  logic [lw:0]        winner_sum;
  logic [lw-1:0]      winner;

  // Round-robin search: rotate requests so ptr sits at bit 0, take the
  // lowest set bit, then rotate the position back to a lane index.
  always_comb begin
    rot_valid = n_lanes'({lane_valid, lane_valid} >> ptr_q);
    first_pos = '0;
    for (int i = n_lanes - 1; i >= 0; i--) begin
      if (rot_valid[i]) first_pos = lw'(i);
    end
    winner_sum = {1'b0, ptr_q} + {1'b0, first_pos};
    if (winner_sum >= (lw+1)'(n_lanes)) begin
      winner_sum = winner_sum - (lw+1)'(n_lanes);
    end
    winner = winner_sum[lw-1:0];
  end

  // Next-state and handshake logic for the IDLE/BUSY word sequencer.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    bit_cnt_d      = bit_cnt_q;
    ptr_d          = ptr_q;
    serial_valid_d = 1'b0;
    serial_data_d  = serial_data_q;
    word_done_d    = 1'b0;
    word_owner_d   = word_owner_q;
    lane_ready     = '0;
    case (state_q)
      IDLE: begin
        if (|lane_valid) begin
          grant_d   = winner;
          bit_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        lane_ready = n_lanes'(1) << grant_q;
        // A stalled lane keeps the grant: a word is never split.
        if (lane_valid[grant_q]) begin
          serial_valid_d = 1'b1;
          serial_data_d  = lane_data[grant_q];
          bit_cnt_d      = bit_cnt_q + 1'b1;
          if (bit_cnt_q == cw'(width - 1)) begin
            bit_cnt_d    = '0;
            word_done_d  = 1'b1;
            word_owner_d = grant_q;
            ptr_d        = (grant_q == lw'(n_lanes - 1)) ? '0 : grant_q + 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SERIAL_LANE_ARB_PRIORITY_EN
    ptr_d = '0;
`else
    ptr_d = ptr_d;
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      bit_cnt_q      <= '0;
      ptr_q          <= '0;
      serial_valid_q <= 1'b0;
      serial_data_q  <= 1'b0;
      word_done_q    <= 1'b0;
      word_owner_q   <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      bit_cnt_q      <= bit_cnt_d;
      ptr_q          <= ptr_d;
      serial_valid_q <= serial_valid_d;
      serial_data_q  <= serial_data_d;
      word_done_q    <= word_done_d;
      word_owner_q   <= word_owner_d;
    end
  end

  assign serial_valid = serial_valid_q;
  assign serial_data  = serial_data_q;
  assign owner        = grant_q;
  assign word_done    = word_done_q;
  assign word_owner   = word_owner_q;
  assign dbg_busy     = (state_q == BUSY);

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Testbench for serial_lane_arbiter (width 8, 4 lanes). Directed table and
// hand sequences plus randomized traffic checked by an observation-level
// reference model running every cycle.
module tb_serial_lane_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] lane_valid;
  logic [3:0] lane_data;
  logic [3:0] lane_ready;
  logic       serial_valid;
  logic       serial_data;
  logic [1:0] owner;
  logic       word_done;
  logic [1:0] word_owner;
  logic       dbg_busy;

  int total = 0;
  int bad   = 0;

  serial_lane_arbiter #(.width(8), .n_lanes(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lane_valid   (lane_valid),
    .lane_data    (lane_data),
    .lane_ready   (lane_ready),
    .serial_valid (serial_valid),
    .serial_data  (serial_data),
    .owner        (owner),
    .word_done    (word_done),
    .word_owner   (word_owner),
    .dbg_busy     (dbg_busy)
  );

  // ---------------- clock / timeout ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // ---------------- shared checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (runs every edge) ----------------
  logic [0:0] exp_q[$];
  int         m_cnt    = 0;
  int         m_ptr    = 0;
  int         m_wowner = 0;
  logic [3:0] ready_snap;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  always @(negedge clk) ready_snap = lane_ready;

  always @(posedge clk) begin
    logic [3:0] pv, pd, pr, acc, exp_ready;
    logic       prst, fin;
    logic [0:0] b;
    int         lane;
    pv = lane_valid; pd = lane_data; pr = ready_snap; prst = rst_n;
    #1;
    if (!prst) begin
      m_cnt = 0; m_ptr = 0; m_wowner = 0;
      exp_q.delete();
      check("m_rst_ready", lane_ready, 0);
      check("m_rst_sv", serial_valid, 0);
      check("m_rst_done", word_done, 0);
      check("m_rst_wowner", word_owner, 0);
    end else begin
      check("m_ready_onehot0", ($countones(pr) <= 1), 1);
      acc = pv & pr;
      fin = 1'b0;
      lane = 0;
      for (int i = 0; i < 4; i++) if (acc[i]) lane = i;
      if (|acc) begin
        exp_q.push_back(pd[lane]);
        m_cnt++;
        if (m_cnt == 8) fin = 1'b1;
      end
      check("m_sv", serial_valid, |acc);
      if (serial_valid) begin
        if (exp_q.size() == 0) begin
          check("m_sd_unexpected", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("m_sd", serial_data, b);
        end
      end
      check("m_done", word_done, fin);
      if (fin) begin
        m_cnt = 0;
        m_wowner = lane;
`ifdef SERIAL_LANE_ARB_PRIORITY_EN
        m_ptr = 0;
`else
        m_ptr = (lane + 1) % 4;
`endif
      end
      check("m_wowner", word_owner, m_wowner);
      if (pr == 0) exp_ready = (|pv) ? (4'b0001 << rr_pick(pv, m_ptr)) : 4'b0000;
      else if (fin) exp_ready = 4'b0000;
      else exp_ready = pr;
      check("m_ready", lane_ready, exp_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] v, input logic [3:0] d);
    @(negedge clk);
    lane_valid = v;
    lane_data  = d;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lane_valid = 4'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] v;
    logic [3:0] d;
    logic [3:0] e_ready;
    logic       e_sv;
    logic       e_sd;
    logic       e_done;
    logic [1:0] e_wo;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] pat;
  logic [7:0] word;
  int         nbits;
  int         n;
  int         owners[8];
  int         at[8];
  int         dones;
  int         wait_steps;
  logic       got_done;

  initial begin
    // reset with all lanes requesting
    rst_n = 1'b0;
    lane_valid = 4'hF;
    lane_data = 4'($urandom);
    repeat (2) @(posedge clk);
    #2;
    check("reset_ready", lane_ready, 0);
    check("reset_sv", serial_valid, 0);
    check("reset_done", word_done, 0);
    check("reset_wowner", word_owner, 0);
    lane_valid = 4'b0;
    rst_n = 1'b1;

    // single lane 2 word: bits 1,0,1,0,0,1,0,1 first to last -> 0xA5
    pat = 8'hA5;
    tbl[0] = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0};
    for (int k = 1; k <= 8; k++) begin
      tbl[k] = '{4'b0100, {1'b0, pat[k-1], 2'b00}, (k == 8) ? 4'b0000 : 4'b0100,
                 1'b1, pat[k-1], (k == 8), (k == 8) ? 2'd2 : 2'd0};
    end
    tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
    word = 8'h00;
    nbits = 0;
    for (int r = 0; r < 10; r++) begin
      step(tbl[r].v, tbl[r].d);
      check($sformatf("tbl%0d_ready", r), lane_ready, tbl[r].e_ready);
      check($sformatf("tbl%0d_sv", r), serial_valid, tbl[r].e_sv);
      if (tbl[r].e_sv) check($sformatf("tbl%0d_sd", r), serial_data, tbl[r].e_sd);
      check($sformatf("tbl%0d_done", r), word_done, tbl[r].e_done);
      check($sformatf("tbl%0d_wowner", r), word_owner, tbl[r].e_wo);
      if (serial_valid && nbits < 8) begin
        word[nbits] = serial_data;
        nbits++;
      end
    end
    check("single_word", word, 8'hA5);

    // all four lanes continuously valid, five words
    do_reset();
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      step(4'hF, 4'($urandom));
      if (word_done) begin owners[n] = word_owner; at[n] = c; n++; end
    end
    check("all4_words", n, 5);
    for (int k = 0; k < n; k++) begin
`ifdef SERIAL_LANE_ARB_PRIORITY_EN
      check($sformatf("all4_owner%0d", k), owners[k], 0);
`else
      check($sformatf("all4_owner%0d", k), owners[k], k % 4);
`endif
      if (k > 0) check($sformatf("all4_gap%0d", k), at[k] - at[k-1], 9);
    end

    // stall: lane 1 granted, drops valid for 3 cycles after 3 bits
    do_reset();
    step(4'b0010, 4'($urandom));
    check("stall_grant", lane_ready, 4'b0010);
    for (int k = 0; k < 3; k++) step(4'b0011, 4'($urandom));
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 4'($urandom));
      check($sformatf("stall_owner%0d", k), owner, 1);
      check($sformatf("stall_rdy0_%0d", k), lane_ready[0], 0);
      check($sformatf("stall_sv%0d", k), serial_valid, 0);
    end
    got_done = 1'b0;
    wait_steps = 0;
    while (!got_done && wait_steps < 12) begin
      step(4'b0011, 4'($urandom));
      wait_steps++;
      if (word_done) begin
        got_done = 1'b1;
        check("stall_wowner", word_owner, 1);
      end
    end
    check("stall_done_seen", got_done, 1);
    check("stall_remaining_bits", wait_steps, 5);

    // reset in the middle of a lane 3 word
    do_reset();
    dones = 0;
    step(4'b1000, 4'($urandom));
    for (int k = 0; k < 5; k++) begin
      step(4'b1000, 4'($urandom));
      if (word_done) dones++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    lane_valid = 4'b1001;
    @(posedge clk);
    #2;
    if (word_done) dones++;
    check("midrst_no_done", dones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("midrst_grant0", lane_ready, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      step(4'b1001, 4'($urandom));
      check($sformatf("midrst_done%0d", k), word_done, (k == 8));
    end
    check("midrst_wowner", word_owner, 0);

    // lanes 0 and 3 continuously valid, four words
    do_reset();
    n = 0;
    for (int c = 0; c < 50 && n < 4; c++) begin
      step(4'b1001, 4'($urandom));
      if (word_done) begin owners[n] = word_owner; n++; end
    end
    check("pair_words", n, 4);
    for (int k = 0; k < n; k++) begin
`ifdef SERIAL_LANE_ARB_PRIORITY_EN
      check($sformatf("pair_owner%0d", k), owners[k], 0);
`else
      check($sformatf("pair_owner%0d", k), owners[k], (k % 2 == 0) ? 0 : 3);
`endif
    end

    // randomized traffic, checked by the reference model each edge
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      lane_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (lane_valid | 4'($urandom));
      lane_data = 4'($urandom);
    end
    @(negedge clk);
    lane_valid = 4'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
